// File: rtl/booth_mult_pkg.sv
// ---------------------------------------------------------------------------
// booth_mult_pkg
// Shared types and sizing for the radix-4 Booth multiplier sequencer.
//   booth_op_e     : per-iteration Booth operation (add 0, +M, +2M, -M, -2M)
//   booth_state_e  : sequencer FSM state (IDLE, RUN, DONE)
//   BOOTH_WIDTH    : default operand/result width (must be even)
//   BOOTH_STEPS    : radix-4 iteration count for the default width
//   booth_steps()  : iteration count for an arbitrary even width
// ---------------------------------------------------------------------------
package booth_mult_pkg;

    localparam int BOOTH_WIDTH = 32;
    localparam int BOOTH_STEPS = BOOTH_WIDTH / 2;

    // Each radix-4 iteration retires two multiplier bits.
    function automatic int booth_steps(input int width);
        return width / 2;
    endfunction

    typedef enum logic [2:0] {
        NOP,
        ADD1,
        ADD2,
        SUB1,
        SUB2
    } booth_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } booth_state_e;

endpackage

// File: rtl/booth_radix4_decode.sv
// ---------------------------------------------------------------------------
// booth_radix4_decode
// Combinational radix-4 Booth recoder: maps the multiplier triplet
// {Q[1], Q[0], q_1} onto the operation applied to the accumulator.
// Ports:
//   triplet  in   3   {Q[1], Q[0], q_1}
//   op       out  booth_op_e  NOP / ADD1 / ADD2 / SUB1 / SUB2
// ---------------------------------------------------------------------------
module booth_radix4_decode
    import booth_mult_pkg::*;
(
    input  logic [2:0] triplet,
    output booth_op_e  op
);

    always_comb begin
        op = NOP;
        unique case (triplet)
            3'b001, 3'b010: op = ADD1;
            3'b011:         op = ADD2;
            3'b100:         op = SUB2;
            3'b101, 3'b110: op = SUB1;
            default:        op = NOP;   // 000 and 111
        endcase
    end

endmodule

// File: rtl/booth_mult_sequencer.sv
// ---------------------------------------------------------------------------
// booth_mult_sequencer
// Radix-4 Booth multiplier sequencer for the multdiv unit. Latches signed
// operands on ctrl_MULT, runs WIDTH/2 Booth iterations (add 0/+-M/+-2M, then
// arithmetic shift right by 2) and returns the low WIDTH product bits with a
// one-cycle ready pulse and an overflow flag.
//
// Optional feature macro: BOOTH_EARLY_TERM_EN
//   When defined, a RUN cycle whose remaining multiplier triplets are all
//   no-ops finishes in one barrel shift and goes straight to DONE.
//
// Ports:
//   clock           in   1        rising-edge clock
//   reset           in   1        asynchronous, active-low
//   ctrl_MULT       in   1        start pulse, operands sampled on same edge
//   data_operandA   in   WIDTH    multiplicand M (two's complement)
//   data_operandB   in   WIDTH    multiplier Q (two's complement)
//   data_result     out  WIDTH    low product bits, held until next start
//   data_resultRDY  out  1        one-cycle pulse: result/exception valid
//   data_exception  out  1        product overflows WIDTH signed bits
//   busy            out  1        high while RUN
//   step            out  STEPS+1  one-hot iteration counter
//   fsm_state       out  booth_state_e  current sequencer state (debug)
//
// Handshake: ctrl_MULT is a single-cycle request with no back-pressure; it is
// always accepted and aborts any operation in flight. data_resultRDY is a
// single-cycle valid with no ready: the consumer must take the result in
// that cycle (data_result/data_exception stay stable afterwards anyway).
// ---------------------------------------------------------------------------
module booth_mult_sequencer
    import booth_mult_pkg::*;
#(
    parameter  int WIDTH = BOOTH_WIDTH,
    localparam int STEPS = booth_steps(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_MULT,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               data_exception,
    output logic               busy,
    output logic [STEPS:0]     step,
    output booth_state_e       fsm_state
);

    // Accumulator carries two guard bits so +-2M never overflows it.
    localparam int AW = WIDTH + 2;
    // Width of the shifted {A, Q, q_1} chain.
    localparam int SW = AW + WIDTH + 1;

    booth_state_e     state_q, state_d;
    logic [AW-1:0]    acc_q;
    logic [AW-1:0]    m_q;
    logic [WIDTH-1:0] q_q;
    logic             q_m1_q;
    logic [STEPS:0]   step_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;

    booth_op_e        op;
    logic [AW-1:0]    addend;
    logic [AW-1:0]    acc_sum;
    logic [SW-1:0]    cur_vec;
    logic [SW-1:0]    shift_vec;
    logic [SW-1:0]    early_vec;
    logic [SW-1:0]    run_next;
    logic             early_hit;
    logic             last_iter;
    logic [AW-1:0]    next_acc;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH:0]   top_bits;
    logic             exc_next;

    booth_radix4_decode u_decode (
        .triplet ({q_q[1:0], q_m1_q}),
        .op      (op)
    );

    always_comb begin
        addend = '0;
        unique case (op)
            ADD1:    addend = m_q;
            ADD2:    addend = m_q << 1;
            SUB1:    addend = -m_q;
            SUB2:    addend = -(m_q << 1);
            default: addend = '0;
        endcase
    end

    assign acc_sum   = acc_q + addend;
    assign cur_vec   = {acc_q, q_q, q_m1_q};
    assign shift_vec = $signed({acc_sum, q_q, q_m1_q}) >>> 2;

`ifdef BOOTH_EARLY_TERM_EN
    // With c iterations done, the unprocessed multiplier bits sit in
    // Q[2r-1:0] (r = STEPS-c) next to q_1. If they all agree every remaining
    // triplet is a no-op, so the rest of the run is a pure 2r-bit shift.
    logic [WIDTH-1:0] rem_mask;

    always_comb begin
        early_hit = 1'b0;
        early_vec = cur_vec;
        rem_mask  = '0;
        for (int c = 0; c < STEPS; c++) begin
            if (step_q[c]) begin
                rem_mask  = {WIDTH{1'b1}} >> (2 * c);
                early_hit = q_m1_q ? ((q_q & rem_mask) == rem_mask)
                                   : ((q_q & rem_mask) == '0);
                early_vec = $signed(cur_vec) >>> (WIDTH - 2 * c);
            end
        end
    end
`else
    assign early_hit = 1'b0;
    assign early_vec = cur_vec;
`endif

    assign run_next  = early_hit ? early_vec : shift_vec;
    assign last_iter = early_hit | step_q[STEPS-1];
    assign next_acc  = run_next[SW-1 -: AW];
    assign next_q    = run_next[WIDTH:1];

    // The product fits in WIDTH signed bits only if the bits from the result
    // sign upward through A[WIDTH-1] are all copies of the same value.
    assign top_bits  = {next_acc[WIDTH-1:0], next_q[WIDTH-1]};
    assign exc_next  = ~((&top_bits) | ~(|top_bits));

    // Next-state logic; a start pulse overrides every state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = IDLE;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (ctrl_MULT) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            m_q      <= '0;
            q_q      <= '0;
            q_m1_q   <= 1'b0;
            step_q   <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (ctrl_MULT) begin
            acc_q  <= '0;
            m_q    <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
            q_q    <= data_operandB;
            q_m1_q <= 1'b0;
            step_q <= {{STEPS{1'b0}}, 1'b1};
        end else begin
            unique case (state_q)
                RUN: begin
                    {acc_q, q_q, q_m1_q} <= run_next;
                    step_q <= early_hit ? {1'b1, {STEPS{1'b0}}} : (step_q << 1);
                    // Result registers change only on the way into DONE.
                    if (last_iter) begin
                        result_q <= next_q;
                        exc_q    <= exc_next;
                    end
                end
                DONE: begin
                    step_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == RUN);
    assign step           = step_q;
    assign fsm_state      = state_q;

endmodule

// File: tb/tb_booth_mult_sequencer.sv
module tb_booth_mult_sequencer;
  import booth_mult_pkg::*;

  localparam int W     = BOOTH_WIDTH;
  localparam int STEPS = W / 2;
`ifdef BOOTH_EARLY_TERM_EN
  localparam bit EARLY_ON = 1'b1;
`else
  localparam bit EARLY_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             ctrl_MULT = 1'b0;
  logic [W-1:0]     data_operandA = '0;
  logic [W-1:0]     data_operandB = '0;
  logic [W-1:0]     data_result;
  logic             data_resultRDY;
  logic             data_exception;
  logic             busy;
  logic [STEPS:0]   step;
  booth_state_e     fsm_state;

  int vectors = 0;
  int miscompares = 0;
  int cycle_cnt = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  booth_mult_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .busy           (busy),
    .step           (step),
    .fsm_state      (fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_exc_q[$];
  int           exp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Reference: full signed product, low W bits, overflow if it does not
  // sign-extend back from those W bits.
  function automatic void model_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] res, output logic exc);
    longint p;
    longint back;
    p    = longint'($signed(a)) * longint'($signed(b));
    res  = p[W-1:0];
    back = longint'($signed(res));
    exc  = (p != back);
  endfunction

  // Iteration count: STEPS normally; with early termination, the first
  // iteration index c whose still-unused multiplier bits B[W-1:2c-1]
  // (B[-1] = 0) are all equal completes at edge c+1.
  function automatic int model_latency(input logic [W-1:0] b);
    longint unsigned ext;
    int early;
    ext   = {31'b0, b, 1'b0};
    early = STEPS;
    for (int c = STEPS - 1; c >= 0; c--) begin
      longint unsigned rem;
      longint unsigned ones;
      rem  = ext >> (2 * c);
      ones = (64'd1 << (W + 1 - 2 * c)) - 64'd1;
      if (rem == 64'd0 || rem == ones) early = c + 1;
    end
    return EARLY_ON ? early : STEPS;
  endfunction

  // Monitor: pops one expectation per ready pulse, flags missing/extra pulses.
  always @(negedge clock) begin
    if (reset) begin
      if (data_resultRDY) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_rdy: got rdy=1 expected no pending op (cycle %0d)", cycle_cnt);
        end else begin
          check("rdy_cycle", 64'(cycle_cnt), 64'(exp_cyc_q[0]));
          check("result", 64'(data_result), 64'(exp_q[0]));
          check("exception", 64'(data_exception), 64'(exp_exc_q[0]));
          void'(exp_q.pop_front());
          void'(exp_exc_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cycle_cnt) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_rdy: got rdy=0 expected rdy at cycle %0d", exp_cyc_q[0]);
        void'(exp_q.pop_front());
        void'(exp_exc_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call at a negedge; returns just after the sampling posedge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int e1;
    logic [W-1:0] r;
    logic x;
    e1 = cycle_cnt + 1;
    // Any op whose ready pulse would fall on or after this start is aborted.
    while (exp_cyc_q.size() > 0 && exp_cyc_q[$] >= e1) begin
      void'(exp_q.pop_back());
      void'(exp_exc_q.pop_back());
      void'(exp_cyc_q.pop_back());
    end
    model_mult(a, b, r, x);
    exp_q.push_back(r);
    exp_exc_q.push_back(x);
    exp_cyc_q.push_back(e1 + model_latency(b));
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
  endtask

  // Always returns on a negedge.
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (exp_q.size() > 0 && n < 200);
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got %0d pending ops expected 0", exp_q.size());
      exp_q.delete();
      exp_exc_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0]   corners [4];
  logic [STEPS:0] exp_step;
  int             e0;

  initial begin
    corners[0] = '0;
    corners[1] = '1;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;

    // Reset state
    @(negedge clock);
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    check("reset_exc", 64'(data_exception), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_step", 64'(step), 64'd0);
    check("reset_state", 64'(fsm_state), 64'(IDLE));
    reset = 1'b1;
    @(negedge clock);

    // Directed products
    start_op(32'd7, -32'sd3);
    wait_idle();
    repeat (3) @(negedge clock);
    check("held_result", 64'(data_result), 64'hFFFF_FFEB);
    check("held_exc", 64'(data_exception), 64'd0);
    check("held_rdy", 64'(data_resultRDY), 64'd0);

    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    start_op(32'h0001_0000, 32'h0001_0000);
    wait_idle();
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();

    // Restart mid-run: first op aborted, only the second reports
`ifdef BOOTH_EARLY_TERM_EN
    start_op(32'd9, 32'h7FFF_0009);
`else
    start_op(32'd9, 32'd9);
`endif
    e0 = cycle_cnt;
    do @(negedge clock); while (cycle_cnt < e0 + 5);
    exp_step    = '0;
    exp_step[5] = 1'b1;
    check("abort_step_bit5", 64'(step), 64'(exp_step));
    check("abort_busy", 64'(busy), 64'd1);
    start_op(32'd3, 32'd4);
    wait_idle();

    // Early-termination candidates (full length when the feature is off)
    start_op(32'd5, 32'd0);
    wait_idle();
    start_op(32'd5, 32'd3);
    wait_idle();

    // Start issued in the DONE cycle of the previous op
    start_op(32'd11, 32'd13);
    do @(negedge clock); while (!data_resultRDY && exp_q.size() > 0);
    start_op(-32'sd6, 32'd7);
    wait_idle();

    // Randomized traffic with occasional aborts
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom();
      if ($urandom_range(0, 3) == 0) a = corners[$urandom_range(0, 3)];
      case ($urandom_range(0, 3))
        0:       b = $urandom();
        1:       b = W'($urandom_range(0, 15)) - W'(8);
        2:       b = {8'($urandom()), 24'h0};
        default: b = corners[$urandom_range(0, 3)];
      endcase
      start_op(a, b);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 10)) @(negedge clock);
      end else begin
        wait_idle();
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
    end
    wait_idle();

    // Asynchronous reset in the middle of a run
    start_op(32'd123, 32'd456);
    repeat (4) @(negedge clock);
    #2;
    reset = 1'b0;
    exp_q.delete();
    exp_exc_q.delete();
    exp_cyc_q.delete();
    #1;
    check("areset_result", 64'(data_result), 64'd0);
    check("areset_rdy", 64'(data_resultRDY), 64'd0);
    check("areset_exc", 64'(data_exception), 64'd0);
    check("areset_busy", 64'(busy), 64'd0);
    check("areset_step", 64'(step), 64'd0);
    check("areset_state", 64'(fsm_state), 64'(IDLE));
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("post_reset_rdy", 64'(data_resultRDY), 64'd0);
    end
    check("post_reset_busy", 64'(busy), 64'd0);

    // Operation after reset recovery
    start_op(32'd1000, -32'sd1000);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
